// File: rtl/mosaic_pkg.sv
// Shared types and defaults for the PPU BG mosaic controller.
package mosaic_pkg;
    localparam int MOSAIC_SIZE_W_DEF = 4;
    localparam int MOSAIC_NUM_BG_DEF = 4;

    typedef logic [MOSAIC_SIZE_W_DEF-1:0] mosaic_size_t;

    typedef struct packed {
        mosaic_size_t                  size;
        logic [MOSAIC_NUM_BG_DEF-1:0]  en;
    } mosaic_cfg_t;
endpackage

// File: rtl/mosaic_phase_ctr.sv
// Wrapping mosaic phase counter: counts 0..size, clear has priority over step.
import mosaic_pkg::*;

module mosaic_phase_ctr #(
    parameter int SIZE_W = MOSAIC_SIZE_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              step,
    input  logic [SIZE_W-1:0] size,
    output logic [SIZE_W-1:0] ctr
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctr <= '0;
        end else if (clr) begin
            ctr <= '0;
        end else if (step) begin
            // >= rather than == so a size shrunk below the current phase still wraps
            ctr <= (ctr >= size) ? '0 : ctr + SIZE_W'(1);
        end
    end
endmodule

// File: rtl/mosaic_ctrl_multi.sv
// Multi-channel BG mosaic controller: shadowed size/enable applied on line or
// frame boundaries, shared X/Y phase counters gated per BG channel.
import mosaic_pkg::*;

module mosaic_ctrl_multi #(
    parameter int NUM_BG = MOSAIC_NUM_BG_DEF,
    parameter int SIZE_W = MOSAIC_SIZE_W_DEF,
    parameter int M7_CH  = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     dot_en,
    input  logic                     newframe,
    input  logic                     newline,
    input  logic                     period_start,
    input  logic                     cfg_wr,
    input  logic [SIZE_W-1:0]        cfg_size,
    input  logic [NUM_BG-1:0]        cfg_en,
    output logic [SIZE_W-1:0]        size_q,
    output logic [NUM_BG-1:0]        en_q,
    output logic [NUM_BG-1:0]        pixel_strobe,
    output logic [NUM_BG*SIZE_W-1:0] yofs_subtract,
    output logic [SIZE_W-1:0]        x_subtract_m7,
    output logic [SIZE_W-1:0]        y_subtract_m7
);
    logic [SIZE_W-1:0] pend_size;
    logic [NUM_BG-1:0] pend_en;
    logic              pend_vld;
    logic              apply;
    logic [SIZE_W-1:0] x_ctr;
    logic [SIZE_W-1:0] y_ctr;

    assign apply = dot_en & (newline | newframe) & pend_vld;

    // Pending data needs no reset: it is only consumed while pend_vld is set.
    always_ff @(posedge clk) begin
        if (cfg_wr) begin
            pend_size <= cfg_size;
            pend_en   <= cfg_en;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            size_q   <= '0;
            en_q     <= '0;
            pend_vld <= 1'b0;
        end else if (apply) begin
            // A write landing on the apply edge bypasses the shadow register
            size_q   <= cfg_wr ? cfg_size : pend_size;
            en_q     <= cfg_wr ? cfg_en   : pend_en;
            pend_vld <= 1'b0;
        end else if (cfg_wr) begin
            pend_vld <= 1'b1;
        end
    end

    mosaic_phase_ctr #(.SIZE_W(SIZE_W)) u_x_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (dot_en & period_start),
        .step    (dot_en),
        .size    (size_q),
        .ctr     (x_ctr)
    );

    // Y restarts its block whenever a new size lands on a line boundary
    mosaic_phase_ctr #(.SIZE_W(SIZE_W)) u_y_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (dot_en & (newframe | (newline & apply))),
        .step    (dot_en & newline),
        .size    (size_q),
        .ctr     (y_ctr)
    );

    for (genvar i = 0; i < NUM_BG; i++) begin : g_ch
        assign pixel_strobe[i]                  = ~en_q[i] | (x_ctr == '0);
        assign yofs_subtract[i*SIZE_W +: SIZE_W] = en_q[i] ? y_ctr : '0;
    end

    assign x_subtract_m7 = en_q[M7_CH] ? x_ctr : '0;
    assign y_subtract_m7 = en_q[M7_CH] ? y_ctr : '0;
endmodule

// File: tb/tb_mosaic_ctrl_multi.sv
// Bench for mosaic_ctrl_multi: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_mosaic_ctrl_multi;
    localparam int NB = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          dot_en, newframe, newline, period_start, cfg_wr;
    logic [SW-1:0] cfg_size;
    logic [NB-1:0] cfg_en;
    logic [SW-1:0] size_q;
    logic [NB-1:0] en_q;
    logic [NB-1:0] pixel_strobe;
    logic [NB*SW-1:0] yofs_subtract;
    logic [SW-1:0] x_subtract_m7, y_subtract_m7;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state: phases and configuration as the rules describe them
    int m_x, m_y, m_size, m_en, m_psize, m_pen;
    bit m_pvld;

    mosaic_ctrl_multi #(.NUM_BG(NB), .SIZE_W(SW), .M7_CH(0)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .dot_en        (dot_en),
        .newframe      (newframe),
        .newline       (newline),
        .period_start  (period_start),
        .cfg_wr        (cfg_wr),
        .cfg_size      (cfg_size),
        .cfg_en        (cfg_en),
        .size_q        (size_q),
        .en_q          (en_q),
        .pixel_strobe  (pixel_strobe),
        .yofs_subtract (yofs_subtract),
        .x_subtract_m7 (x_subtract_m7),
        .y_subtract_m7 (y_subtract_m7)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_size = 0; m_en = 0; m_pvld = 0;
    endtask

    task automatic model_edge(input bit de, nf, nl, ps, wr, input int sz, input int en);
        bit ap;
        int nx, ny;
        ap = de && (nl || nf) && m_pvld;
        nx = m_x; ny = m_y;
        if (de) begin
            nx = ps ? 0 : ((m_x >= m_size) ? 0 : m_x + 1);
            if (nf)            ny = 0;
            else if (nl && ap) ny = 0;
            else if (nl)       ny = (m_y >= m_size) ? 0 : m_y + 1;
        end
        if (ap) begin
            m_size = wr ? sz : m_psize;
            m_en   = wr ? en : m_pen;
            m_pvld = 0;
        end else if (wr) begin
            m_psize = sz; m_pen = en; m_pvld = 1;
        end
        m_x = nx; m_y = ny;
    endtask

    task automatic check_model(input string name);
        logic [NB-1:0]    e_str;
        logic [NB*SW-1:0] e_yofs;
        logic [SW-1:0]    e_xm, e_ym;
        for (int i = 0; i < NB; i++) begin
            e_str[i]            = !m_en[i] || (m_x == 0);
            e_yofs[i*SW +: SW]  = m_en[i] ? SW'(m_y) : '0;
        end
        e_xm = m_en[0] ? SW'(m_x) : '0;
        e_ym = m_en[0] ? SW'(m_y) : '0;
        chk(name, {28'd0, size_q, en_q, pixel_strobe, yofs_subtract, x_subtract_m7, y_subtract_m7},
                  {28'd0, SW'(m_size), NB'(m_en), e_str, e_yofs, e_xm, e_ym});
    endtask

    task automatic tick(input bit de, nf, nl, ps, wr, input int sz, input int en);
        dot_en = de; newframe = nf; newline = nl; period_start = ps;
        cfg_wr = wr; cfg_size = SW'(sz); cfg_en = NB'(en);
        @(posedge clk);
        model_edge(de, nf, nl, ps, wr, sz, en);
        #1;
        check_model("model");
    endtask

    task automatic dot(input bit nf, nl, ps);
        tick(1, nf, nl, ps, 0, 0, 0);
    endtask

    task automatic wr_cfg(input int sz, input int en);
        tick(0, 0, 0, 0, 1, sz, en);
    endtask

    typedef struct {
        bit            de, nf, nl, ps, wr;
        int            sz, en;
        logic [SW-1:0] e_size;
        logic [NB-1:0] e_str;
        logic [SW-1:0] e_xm;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // size 3, mask 0001: write, apply on newline, then a line of dots
        tbl[0] = '{0,0,0,0,1, 3,1, 4'd0, 4'b1111, 4'd0};
        tbl[1] = '{1,0,1,0,0, 0,0, 4'd3, 4'b1111, 4'd0};
        tbl[2] = '{1,0,0,1,0, 0,0, 4'd3, 4'b1111, 4'd0};
        tbl[3] = '{1,0,0,0,0, 0,0, 4'd3, 4'b1110, 4'd1};
        tbl[4] = '{1,0,0,0,0, 0,0, 4'd3, 4'b1110, 4'd2};
        tbl[5] = '{1,0,0,0,0, 0,0, 4'd3, 4'b1110, 4'd3};
        tbl[6] = '{1,0,0,0,0, 0,0, 4'd3, 4'b1111, 4'd0};
        tbl[7] = '{1,0,0,0,0, 0,0, 4'd3, 4'b1110, 4'd1};
        tbl[8] = '{1,0,0,0,0, 0,0, 4'd3, 4'b1110, 4'd2};
        tbl[9] = '{1,0,0,0,0, 0,0, 4'd3, 4'b1110, 4'd3};

        reset_n = 1'b0;
        dot_en = 0; newframe = 0; newline = 0; period_start = 0;
        cfg_wr = 0; cfg_size = '0; cfg_en = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_outputs", {size_q, en_q, pixel_strobe, yofs_subtract, x_subtract_m7, y_subtract_m7},
                             {4'd0, 4'd0, 4'hF, 16'd0, 4'd0, 4'd0});

        // No writes: random line/frame activity must leave the reset outputs untouched
        for (int i = 0; i < 1000; i++) begin
            dot(($urandom_range(99) == 0), ($urandom_range(19) == 0), ($urandom_range(19) == 0));
            if (i % 100 == 0)
                chk("idle_outputs", {pixel_strobe, yofs_subtract, x_subtract_m7, y_subtract_m7},
                                    {4'hF, 16'd0, 4'd0, 4'd0});
        end

        for (int i = 0; i < 10; i++) begin
            tick(tbl[i].de, tbl[i].nf, tbl[i].nl, tbl[i].ps, tbl[i].wr, tbl[i].sz, tbl[i].en);
            chk($sformatf("vec%0d", i), {size_q, pixel_strobe, x_subtract_m7},
                                        {tbl[i].e_size, tbl[i].e_str, tbl[i].e_xm});
        end

        // Y sequence with size 2, then frame start over newline
        wr_cfg(2, 1);
        dot(0, 1, 0); chk("y_seq0", yofs_subtract, 16'd0);
        dot(0, 1, 0); chk("y_seq1", yofs_subtract, 16'd1);
        dot(0, 1, 0); chk("y_seq2", yofs_subtract, 16'd2);
        dot(0, 1, 0); chk("y_seq3", yofs_subtract, 16'd0);
        dot(0, 1, 0); chk("y_seq4", yofs_subtract, 16'd1);
        dot(1, 1, 0); chk("y_newframe", yofs_subtract, 16'd0);

        // Mid-line size change waits for the line boundary
        wr_cfg(3, 1);
        dot(0, 1, 0);
        dot(0, 1, 0); chk("y_before_chg", y_subtract_m7, 4'd1);
        dot(0, 0, 1);
        wr_cfg(7, 1);
        dot(0, 0, 0); chk("midline_x1", {size_q, x_subtract_m7}, {4'd3, 4'd1});
        dot(0, 0, 0); chk("midline_x2", {size_q, x_subtract_m7}, {4'd3, 4'd2});
        dot(0, 0, 0); chk("midline_x3", {size_q, x_subtract_m7}, {4'd3, 4'd3});
        dot(0, 0, 0); chk("midline_x0", {size_q, x_subtract_m7}, {4'd3, 4'd0});
        dot(0, 1, 0); chk("line_apply", {size_q, y_subtract_m7}, {4'd7, 4'd0});

        // Write coinciding with an applying newline bypasses and clears pending
        wr_cfg(4, 1);
        tick(1, 0, 1, 0, 1, 5, 1); chk("bypass_size", size_q, 4'd5);
        dot(0, 1, 0); chk("no_reapply", {size_q, y_subtract_m7}, {4'd5, 4'd1});

        // Mask 1010, size 1: channels 0/2 frozen, 1/3 toggle
        wr_cfg(1, 4'b1010);
        dot(0, 1, 0);
        dot(0, 1, 0);
        dot(0, 0, 1); chk("m1010_x0", {pixel_strobe, yofs_subtract, x_subtract_m7}, {4'b1111, 16'h1010, 4'd0});
        dot(0, 0, 0); chk("m1010_x1", pixel_strobe, 4'b0101);
        dot(0, 0, 0); chk("m1010_x0b", pixel_strobe, 4'b1111);
        dot(0, 0, 0); chk("m1010_x1b", {pixel_strobe, yofs_subtract}, {4'b0101, 16'h1010});

        // Asynchronous reset mid-line
        dot_en = 1; newline = 0; newframe = 0; period_start = 0; cfg_wr = 0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset", {size_q, en_q, pixel_strobe, yofs_subtract, x_subtract_m7, y_subtract_m7},
                           {4'd0, 4'd0, 4'hF, 16'd0, 4'd0, 4'd0});
        @(posedge clk); #1;
        check_model("reset_held");
        #2 reset_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(3) != 0), ($urandom_range(99) == 0), ($urandom_range(15) == 0),
                 ($urandom_range(15) == 0), ($urandom_range(29) == 0),
                 int'($urandom_range(15)), int'($urandom_range(15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
